// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and flag layout.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOT  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_NOR  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_RSVD = 4'b1011;
   localparam logic [3:0] OP_ROL  = 4'b1100;
   localparam logic [3:0] OP_ROR  = 4'b1101;
   localparam logic [3:0] OP_MULU = 4'b1110;
   localparam logic [3:0] OP_DIVU = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   localparam int FLG_ZERO = 0;
   localparam int FLG_COUT = 1;
   localparam int FLG_OVF  = 2;
   localparam int FLG_DIV0 = 3;
   localparam int FLG_N    = 4;

   function automatic logic is_iter(input logic [3:0] op);
      return (op == OP_MULU) || (op == OP_DIVU);
   endfunction

   function automatic logic [FLG_N-1:0] mk_flags(input logic z, input logic c,
                                                 input logic o, input logic d);
      logic [FLG_N-1:0] f;
      f           = '0;
      f[FLG_ZERO] = z;
      f[FLG_COUT] = c;
      f[FLG_OVF]  = o;
      f[FLG_DIV0] = d;
      return f;
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU ops with carry/overflow; iterative and reserved codes give zero.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_op,
   output logic [WIDTH-1:0] o_res,
   output logic             o_cout,
   output logic             o_ovf
);

   logic [SHW-1:0] w_sh;
   logic [SHW:0]   w_sh_inv;
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   assign w_sh     = i_b[SHW-1:0];
   // Complementary amount for rotates; equals WIDTH when w_sh is 0, which shifts everything out.
   assign w_sh_inv = (SHW+1)'(WIDTH) - {1'b0, w_sh};
   assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff   = {1'b0, i_a} - {1'b0, i_b};

   // Operation select and flag generation
   always_comb begin
      o_res  = '0;
      o_cout = 1'b0;
      o_ovf  = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_res  = w_sum[WIDTH-1:0];
            o_cout = w_sum[WIDTH];
            o_ovf  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_SUB: begin
            o_res  = w_diff[WIDTH-1:0];
            o_cout = ~w_diff[WIDTH];
            o_ovf  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_AND:  o_res = i_a & i_b;
         OP_OR:   o_res = i_a | i_b;
         OP_NOT:  o_res = ~i_a;
         OP_NAND: o_res = ~(i_a & i_b);
         OP_NOR:  o_res = ~(i_a | i_b);
         OP_XOR:  o_res = i_a ^ i_b;
         OP_SRA:  o_res = $signed(i_a) >>> w_sh;
         OP_SRL:  o_res = i_a >> w_sh;
         OP_SLL:  o_res = i_a << w_sh;
         OP_ROL:  o_res = (i_a << w_sh) | (i_a >> w_sh_inv);
         OP_ROR:  o_res = (i_a >> w_sh) | (i_a << w_sh_inv);
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input, one-cycle result strobe and
// iterative shift-add multiply / restoring divide.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Op,
   output logic [WIDTH-1:0] Out,
   output logic             Out_valid,
   output logic             Zero,
   output logic             Cout,
   output logic             Ovf,
   output logic             Div0
);

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_out;
   logic [FLG_N-1:0]   r_flags;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc;
   logic [SHW-1:0]     r_cnt;

   logic               w_accept;
   logic [WIDTH-1:0]   w_res;
   logic               w_cout;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_mul_acc;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_trial;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_rem_nx;
   logic [WIDTH-1:0]   w_quo_nx;

   alu_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
      .i_a    (A),
      .i_b    (B),
      .i_op   (Op),
      .o_res  (w_res),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   assign In_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept  = In_valid && In_ready;

   // Multiplier: r_a is the left-shifting multiplicand, r_b the right-shifting multiplier.
   assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

   // Divider: r_acc is the partial remainder, r_a shifts dividend bits out and quotient bits in.
   assign w_rem_sh  = {r_acc, r_a[WIDTH-1]};
   assign w_trial   = w_rem_sh - {1'b0, r_b};
   assign w_qbit    = ~w_trial[WIDTH];
   assign w_rem_nx  = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quo_nx  = {r_a[WIDTH-2:0], w_qbit};

   // Control FSM, operand/iteration registers and output registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_out       <= '0;
         r_flags     <= mk_flags(1'b1, 1'b0, 1'b0, 1'b0);
         r_out_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_state <= ST_IDLE;
               if (w_accept) begin
                  if (is_iter(Op)) begin
                     r_state <= (Op == OP_MULU) ? ST_MUL : ST_DIV;
                     r_a     <= A;
                     r_b     <= B;
                     r_acc   <= '0;
                     r_cnt   <= CNT_LAST;
                  end else begin
                     r_out       <= w_res;
                     r_flags     <= mk_flags(w_res == '0, w_cout, w_ovf, 1'b0);
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               r_acc <= w_mul_acc;
               r_a   <= r_a << 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt - SHW'(1);
               if (r_cnt == '0) begin
                  r_state     <= ST_DONE;
                  r_out       <= w_mul_acc;
                  r_flags     <= mk_flags(w_mul_acc == '0, 1'b0, 1'b0, 1'b0);
                  r_out_valid <= 1'b1;
               end
            end
            ST_DIV: begin
               // Zero divisor short-circuits with a saturated quotient.
               if (r_b == '0) begin
                  r_state     <= ST_DONE;
                  r_out       <= '1;
                  r_flags     <= mk_flags(1'b0, 1'b0, 1'b0, 1'b1);
                  r_out_valid <= 1'b1;
               end else begin
                  r_acc <= w_rem_nx;
                  r_a   <= w_quo_nx;
                  r_cnt <= r_cnt - SHW'(1);
                  if (r_cnt == '0) begin
                     r_state     <= ST_DONE;
                     r_out       <= w_quo_nx;
                     r_flags     <= mk_flags(w_quo_nx == '0, 1'b0, 1'b0, 1'b0);
                     r_out_valid <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Out       = r_out;
   assign Out_valid = r_out_valid;
   assign Zero      = r_flags[FLG_ZERO];
   assign Cout      = r_flags[FLG_COUT];
   assign Ovf       = r_flags[FLG_OVF];
   assign Div0      = r_flags[FLG_DIV0];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_seq;
   import alu_pkg::*;

   typedef struct {
      longint unsigned out;
      bit              z;
      bit              c;
      bit              o;
      bit              d;
      int              lat;
      int              due;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic        v32 = 1'b0, rdy32, ov32, z32, c32, o32, d32;
   logic [31:0] a32 = '0, b32 = '0, out32;
   logic [3:0]  op32 = '0;
   logic        v8 = 1'b0, rdy8, ov8, z8, c8, o8, d8;
   logic [7:0]  a8 = '0, b8 = '0, out8;
   logic [3:0]  op8 = '0;

   exp_t q32[$];
   exp_t q8[$];

   alu_seq #(.WIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .In_valid(v32), .In_ready(rdy32), .A(a32), .B(b32), .Op(op32),
      .Out(out32), .Out_valid(ov32), .Zero(z32), .Cout(c32), .Ovf(o32), .Div0(d32));

   alu_seq #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Reset(Reset), .In_valid(v8), .In_ready(rdy8), .A(a8), .B(b8), .Op(op8),
      .Out(out8), .Out_valid(ov8), .Zero(z8), .Cout(c8), .Ovf(o8), .Div0(d8));

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic bit msb(input int w, input longint unsigned x);
      return x[w-1];
   endfunction

   // Reference: plain arithmetic on unsigned values masked to w bits.
   function automatic exp_t model(input int w, input logic [3:0] op,
                                  input longint unsigned a_in, input longint unsigned b_in);
      exp_t e;
      longint unsigned m = (64'd1 << w) - 64'd1;
      longint unsigned a = a_in & m;
      longint unsigned b = b_in & m;
      int sh = int'(b % longint'(w));
      longint sa;
      longint unsigned r = 0;
      e.c = 0; e.o = 0; e.d = 0; e.lat = 1; e.due = 0;
      case (op)
         OP_ADD: begin
            r = a + b;
            e.c = ((r >> w) & 64'd1) == 64'd1;
            r &= m;
            e.o = (msb(w, a) == msb(w, b)) && (msb(w, r) != msb(w, a));
         end
         OP_SUB: begin
            r = (a - b) & m;
            e.c = (a >= b);
            e.o = (msb(w, a) != msb(w, b)) && (msb(w, r) != msb(w, a));
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NOT:  r = ~a & m;
         OP_NAND: r = ~(a & b) & m;
         OP_NOR:  r = ~(a | b) & m;
         OP_XOR:  r = a ^ b;
         OP_SRA: begin
            sa = msb(w, a) ? (longint'(a) - longint'(m) - 64'sd1) : longint'(a);
            r  = longint'(sa >>> sh) & m;
         end
         OP_SRL:  r = a >> sh;
         OP_SLL:  r = (a << sh) & m;
         OP_ROL:  r = ((a << sh) | (a >> (w - sh))) & m;
         OP_ROR:  r = ((a >> sh) | (a << (w - sh))) & m;
         OP_MULU: begin
            r = (a * b) & m;
            e.lat = w + 1;
         end
         OP_DIVU: begin
            if (b == 0) begin
               r = m; e.d = 1; e.lat = 2;
            end else begin
               r = a / b; e.lat = w + 1;
            end
         end
         default: r = 0;
      endcase
      e.out = r;
      e.z   = (r == 0);
      return e;
   endfunction

   // Present one op; the scoreboard entry carries the cycle its result must appear in.
   task automatic issue(input bit sel8, input logic [3:0] op, input longint unsigned a,
                        input longint unsigned b, input bit use_lit = 0,
                        input longint unsigned lit = 0);
      exp_t e;
      int guard = 0;
      @(negedge Clk);
      while (!(sel8 ? rdy8 : rdy32) && guard < 200) begin
         @(negedge Clk);
         guard++;
      end
      if (guard >= 200) chk("issue_ready_timeout", 0, 1);
      e = model(sel8 ? 8 : 32, op, a, b);
      if (use_lit) e.out = lit;
      e.due = cyc + e.lat;
      if (sel8) begin
         v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
         q8.push_back(e);
      end else begin
         v32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
         q32.push_back(e);
      end
      @(posedge Clk);
      #1;
      // Scramble inputs once accepted; the DUT must ignore them.
      v32 = 1'b0; v8 = 1'b0;
      a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      while ((q32.size() != 0 || q8.size() != 0) && guard < 2000) begin
         @(negedge Clk);
         guard++;
      end
      chk("drain_q32_empty", q32.size(), 0);
      chk("drain_q8_empty", q8.size(), 0);
   endtask

   // Monitor for the 32-bit instance
   always @(negedge Clk) begin : mon32
      exp_t e;
      if (!Reset && ov32) begin
         if (q32.size() == 0) begin
            checks++; failures++;
            $display("FAIL w32_unexpected_valid got out=%0h expected no strobe", out32);
         end else begin
            e = q32.pop_front();
            chk("w32_latency", cyc, e.due);
            chk("w32_out", out32, e.out);
            chk("w32_zero", z32, e.z);
            chk("w32_cout", c32, e.c);
            chk("w32_ovf", o32, e.o);
            chk("w32_div0", d32, e.d);
         end
      end
   end

   // Monitor for the 8-bit instance
   always @(negedge Clk) begin : mon8
      exp_t e;
      if (!Reset && ov8) begin
         if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL w8_unexpected_valid got out=%0h expected no strobe", out8);
         end else begin
            e = q8.pop_front();
            chk("w8_latency", cyc, e.due);
            chk("w8_out", out8, e.out);
            chk("w8_zero", z8, e.z);
            chk("w8_cout", c8, e.c);
            chk("w8_ovf", o8, e.o);
            chk("w8_div0", d8, e.d);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      longint unsigned ra, rb;
      logic [3:0] rop;
      repeat (3) @(negedge Clk);
      chk("rst_out", out32, 0);
      chk("rst_zero", z32, 1);
      chk("rst_valid", ov32, 0);
      chk("rst_flags", {c32, o32, d32}, 0);
      chk("rst_ready", rdy32, 1);
      chk("rst8_ready_zero", {rdy8, z8, ov8}, 3'b110);
      Reset = 1'b0;

      issue(0, OP_ADD, 1, 2, 1, 3);
      issue(0, OP_ADD, 64'h7FFFFFFF, 1, 1, 64'h80000000);
      issue(0, OP_SUB, 5, 5, 1, 0);
      issue(0, OP_ROR, 64'h0000000F, 4, 1, 64'hF0000000);
      issue(0, OP_SRA, 64'h80000000, 31, 1, 64'hFFFFFFFF);
      issue(0, OP_SLL, 64'h12345678, 0, 1, 64'h12345678);
      issue(0, OP_ROL, 64'h80000001, 32, 1, 64'h80000001);
      issue(0, OP_RSVD, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 0);

      issue(0, OP_MULU, 7, 6, 1, 42);
      for (int k = 0; k < 32; k++) begin
         @(negedge Clk);
         chk("mulu_busy_not_ready", rdy32, 0);
      end
      drain();
      issue(1, OP_MULU, 20, 20, 1, 8'h90);
      issue(0, OP_DIVU, 100, 7, 1, 14);
      issue(0, OP_DIVU, 9, 0, 1, 64'hFFFFFFFF);
      issue(0, OP_ADD, 64'hFFFFFFFF, 1, 1, 0);
      issue(0, OP_XOR, 64'hF0F0F0F0, 64'hFF00FF00, 1, 64'h0FF00FF0);
      issue(0, OP_OR, 64'h00000011, 64'h00000100, 1, 64'h00000111);
      drain();

      // Abort a multiply with reset: no strobe may follow.
      issue(0, OP_MULU, 3, 5);
      void'(q32.pop_back());
      repeat (4) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk("abort_valid", ov32, 0);
      chk("abort_out", out32, 0);
      chk("abort_ready", rdy32, 1);
      chk("abort_zero", z32, 1);
      Reset = 1'b0;
      repeat (40) @(negedge Clk);

      for (int i = 0; i < 160; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom_range(0, 40);
            1: rb = 0;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 4) == 0) ra = (i % 2 == 0) ? 64'hFFFFFFFF : 64'h80000000;
         issue(i % 3 == 0, rop, ra, rb);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
